gray_sync_decoder: RTL and testbench

Downstream consumer of the binary-to-Gray stage. It takes a Gray-coded count produced in another timing domain and passes it through a multi-flop synchronizer. It then decodes it to binary and registers the result. It also reports per-update direction and flags illegal multi-bit Gray steps. The decoded value feeds local pointer/compare logic, e.g. FIFO occupancy.

---
 rtl/gray_sync_decoder.sv | 118 +++++++++++
 tb/tb_gray_sync_decoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/gray_sync_decoder.sv
// Synchronizes a Gray-coded count from another clock domain and decodes it to binary.
// Flags single-step direction and counts illegal multi-bit Gray steps.
module gray_sync_decoder #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 dir,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 primed
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {FILL, PRIME, RUN} state_t;

  state_t                           state, state_nxt;
  logic [CNT_W-1:0]                 fill_cnt, fill_nxt;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] s;
  logic [WIDTH-1:0]                 sync, sync_bin, diff, bin_inc;
  logic [WIDTH-1:0]                 g_prev, g_prev_nxt, bin_nxt;
  logic                             valid_nxt, dir_nxt, err_nxt, primed_nxt;
  logic [ERR_CNT_W-1:0]             cnt_nxt;
  logic                             d_zero, d_one;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign sync     = s[SYNC_STAGES-1];
  assign sync_bin = gray2bin(sync);
  assign diff     = sync ^ g_prev;
  assign bin_inc  = bin_out + WIDTH'(1);
  // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero.
  assign d_zero   = (diff == '0);
  assign d_one    = !d_zero && ((diff & (diff - WIDTH'(1))) == '0);

  // Next-state and output logic.
  always_comb begin
    state_nxt  = state;
    fill_nxt   = fill_cnt;
    bin_nxt    = bin_out;
    g_prev_nxt = g_prev;
    valid_nxt  = 1'b0;
    dir_nxt    = dir;
    primed_nxt = primed;
    err_nxt    = err_clr ? 1'b0 : step_err;
    cnt_nxt    = err_clr ? '0 : err_cnt;
    case (state)
      FILL: begin
        fill_nxt = fill_cnt + CNT_W'(1);
        if (fill_cnt == CNT_W'(SYNC_STAGES - 1)) state_nxt = PRIME;
      end
      PRIME: begin
        bin_nxt    = sync_bin;
        g_prev_nxt = sync;
        primed_nxt = 1'b1;
        state_nxt  = RUN;
      end
      RUN: begin
        if (!d_zero) begin
          bin_nxt    = sync_bin;
          g_prev_nxt = sync;
          valid_nxt  = 1'b1;
          if (d_one) begin
            dir_nxt = (sync_bin == bin_inc);
          end else begin
            // Multi-bit step: resync to the new value; a same-cycle clear loses to the set.
            dir_nxt = 1'b0;
            err_nxt = 1'b1;
            if (cnt_nxt != '1) cnt_nxt = cnt_nxt + ERR_CNT_W'(1);
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // State, synchronizer chain and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      fill_cnt  <= '0;
      s         <= '0;
      g_prev    <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      dir       <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
      primed    <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_cnt  <= fill_nxt;
      s         <= {s[SYNC_STAGES-2:0], gray_in};
      g_prev    <= g_prev_nxt;
      bin_out   <= bin_nxt;
      bin_valid <= valid_nxt;
      dir       <= dir_nxt;
      step_err  <= err_nxt;
      err_cnt   <= cnt_nxt;
      primed    <= primed_nxt;
    end
  end

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder: priming, unit steps, wrap, multi-bit errors,
// clear/set priority, counter saturation (second instance) and asynchronous reset.
module tb_gray_sync_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       err_clr;

  logic [3:0] bin_out, bin_out2;
  logic       bin_valid, bin_valid2, dir, dir2, step_err, step_err2, primed, primed2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_sync_decoder #(.WIDTH(4), .SYNC_STAGES(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .err_clr(err_clr),
    .bin_out(bin_out), .bin_valid(bin_valid), .dir(dir), .step_err(step_err),
    .err_cnt(err_cnt), .primed(primed)
  );

  gray_sync_decoder #(.WIDTH(4), .SYNC_STAGES(2), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .err_clr(err_clr),
    .bin_out(bin_out2), .bin_valid(bin_valid2), .dir(dir2), .step_err(step_err2),
    .err_cnt(err_cnt2), .primed(primed2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply one Gray value and check the update SYNC_STAGES+1 edges later.
  task automatic gray_step(input string tag, input logic [3:0] g, input logic [3:0] eb,
                           input logic ed, input logic ee, input int ec, input logic clr);
    int ec2;
    ec2 = (ec > 3) ? 3 : ec;
    gray_in = g;
    step(2);
    check_eq({tag, "_early_valid"}, 32'(bin_valid), 32'd0);
    if (clr) err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check_eq({tag, "_bin"},      32'(bin_out),   32'(eb));
    check_eq({tag, "_valid"},    32'(bin_valid), 32'd1);
    check_eq({tag, "_dir"},      32'(dir),       32'(ed));
    check_eq({tag, "_step_err"}, 32'(step_err),  32'(ee));
    check_eq({tag, "_err_cnt"},  32'(err_cnt),   32'(ec));
    check_eq({tag, "_sat_cnt"},  32'(err_cnt2),  32'(ec2));
    step(1);
    check_eq({tag, "_valid_low"}, 32'(bin_valid), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    gray_in = 4'b0110;
    err_clr = 1'b0;
    step(2);
    check_eq("rst_bin",    32'(bin_out), 32'd0);
    check_eq("rst_primed", 32'(primed),  32'd0);
    check_eq("rst_errcnt", 32'(err_cnt), 32'd0);

    // Priming with a static 0110: bin_out=4 after edge 3.
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step(1);
      check_eq($sformatf("prime_valid_e%0d", e), 32'(bin_valid), 32'd0);
      check_eq($sformatf("prime_err_e%0d", e),   32'(step_err),  32'd0);
      if (e == 2) check_eq("prime_not_yet", 32'(primed), 32'd0);
    end
    check_eq("prime_primed", 32'(primed),  32'd1);
    check_eq("prime_bin",    32'(bin_out), 32'd4);
    step(1);
    check_eq("prime_no_valid", 32'(bin_valid), 32'd0);

    // Re-prime at 0000.
    rst_n   = 1'b0;
    gray_in = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(3);
    check_eq("prime0_primed", 32'(primed),  32'd1);
    check_eq("prime0_bin",    32'(bin_out), 32'd0);
    step(1);

    // Unit up-steps.
    gray_step("up1", 4'b0001, 4'd1, 1'b1, 1'b0, 0, 1'b0);
    gray_step("up2", 4'b0011, 4'd2, 1'b1, 1'b0, 0, 1'b0);
    gray_step("up3", 4'b0010, 4'd3, 1'b1, 1'b0, 0, 1'b0);

    // Down to 0, down-wrap to 15, up-wrap back to 0.
    gray_step("down0",  4'b0000, 4'd0,  1'b0, 1'b0, 0, 1'b0);
    gray_step("wrapdn", 4'b1000, 4'd15, 1'b0, 1'b0, 0, 1'b0);
    gray_step("wrapup", 4'b0000, 4'd0,  1'b1, 1'b0, 0, 1'b0);

    // Multi-bit jump from 0001 to 0110, then a legal step.
    gray_step("to1",   4'b0001, 4'd1, 1'b1, 1'b0, 0, 1'b0);
    gray_step("jump",  4'b0110, 4'd4, 1'b0, 1'b1, 1, 1'b0);
    gray_step("after", 4'b0111, 4'd5, 1'b1, 1'b1, 1, 1'b0);

    // Clear coincident with a jump: set wins.
    gray_step("clr_set", 4'b0000, 4'd0, 1'b0, 1'b1, 1, 1'b1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check_eq("clr_err", 32'(step_err), 32'd0);
    check_eq("clr_cnt", 32'(err_cnt),  32'd0);
    check_eq("clr_sat", 32'(err_cnt2), 32'd0);

    // Five errors: 8-bit counter reaches 5, 2-bit counter saturates at 3.
    gray_step("e1", 4'b0101, 4'd6, 1'b0, 1'b1, 1, 1'b0);
    gray_step("e2", 4'b0000, 4'd0, 1'b0, 1'b1, 2, 1'b0);
    gray_step("e3", 4'b0101, 4'd6, 1'b0, 1'b1, 3, 1'b0);
    gray_step("e4", 4'b0000, 4'd0, 1'b0, 1'b1, 4, 1'b0);
    gray_step("e5", 4'b0101, 4'd6, 1'b0, 1'b1, 5, 1'b0);

    // Reach bin 9, then reset mid-cycle.
    gray_step("to9", 4'b1101, 4'd9, 1'b0, 1'b1, 5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_bin",    32'(bin_out),  32'd0);
    check_eq("arst_primed", 32'(primed),   32'd0);
    check_eq("arst_err",    32'(step_err), 32'd0);
    check_eq("arst_cnt",    32'(err_cnt),  32'd0);
    check_eq("arst_dir",    32'(dir),      32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    check_eq("rep_not_primed", 32'(primed),    32'd0);
    check_eq("rep_valid_e2",   32'(bin_valid), 32'd0);
    step(1);
    check_eq("rep_primed", 32'(primed),    32'd1);
    check_eq("rep_bin",    32'(bin_out),   32'd9);
    check_eq("rep_err",    32'(step_err),  32'd0);
    check_eq("rep_valid",  32'(bin_valid), 32'd0);
    step(1);
    check_eq("rep_hold_valid", 32'(bin_valid), 32'd0);
    check_eq("rep_hold_err",   32'(step_err),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
